cpu_io_bridge: RTL and testbench



---
 rtl/cpu_io_bridge_if.sv | 37 +++
 rtl/cpu_io_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_cpu_io_bridge.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_io_bridge_if.sv
// Bus bundle between the Z80 I/O pins and the peripheral request ports.
//
// Handshake: the bridge raises exactly one bit of req for a single cycle
// per decoded transaction, and wr/data_out are stable while it is high.
// The selected peripheral answers with a one-cycle (or longer) ack on its
// own bit, starting no earlier than the cycle after req. For a read,
// data_in for that channel must be valid in the same cycle as ack.
// ack bits of channels other than the selected one are ignored.
interface cpu_io_bridge_if #(
  parameter int NUM_CH = 2
);
  logic [5:0]          A;
  logic                rd_iorq_n;
  logic                wr_iorq_n;
  logic [7:0]          cd_in;
  logic [7:0]          cd_out;
  logic                cd_oe;
  logic                cs_n;
  logic [NUM_CH-1:0]   req;
  logic                wr;
  logic [7:0]          data_out;
  logic [NUM_CH*8-1:0] data_in;
  logic [NUM_CH-1:0]   ack;
  logic                timeout;

  // Bridge side
  modport slave (
    input  A, rd_iorq_n, wr_iorq_n, cd_in, data_in, ack,
    output cd_out, cd_oe, cs_n, req, wr, data_out, timeout
  );

  // CPU pins plus peripherals, as seen from outside the bridge
  modport master (
    output A, rd_iorq_n, wr_iorq_n, cd_in, data_in, ack,
    input  cd_out, cd_oe, cs_n, req, wr, data_out, timeout
  );
endinterface

// File: rtl/cpu_io_bridge.sv
// Z80 I/O-bus bridge: synchronises the async I/O strobes, decodes A[7:2]
// against per-channel base/mask pairs, issues a single-cycle request to the
// selected peripheral, waits for ack (with timeout) and drives read data
// back to the CPU until the strobe is released.
module cpu_io_bridge #(
  parameter int                  NUM_CH      = 2,
  // Channel 0 sits in the LSBs: channel 0 = 6'h26, channel 1 = 6'h14.
  parameter logic [NUM_CH*6-1:0] CH_BASE     = {6'h14, 6'h26},
  parameter logic [NUM_CH*6-1:0] CH_MASK     = {6'h3F, 6'h3F},
  parameter int                  SYNC_STAGES = 2,
  parameter int                  ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cpu_io_bridge_if.slave        bus,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    ST_ARM  = 3'd0,
    ST_IDLE = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
  logic                   rd_prev, wr_prev;
  logic                   rd_s, wr_s;

  // ARM flush counter: the synchroniser resets to 1, so ARM must let the
  // real pin level propagate through every stage before trusting "high".
  logic [1:0]        arm_cnt_q, arm_cnt_d;
  logic [NUM_CH-1:0] sel_q, sel_d;
  logic              rd_txn_q, rd_txn_d;   // matched read in progress
  logic              is_wr_q, is_wr_d;
  logic              rose_q, rose_d;       // active strobe seen high mid-transaction
  logic [7:0]        cnt_q, cnt_d;

  logic              cs_n_q, cs_n_d;
  logic              cd_oe_q, cd_oe_d;
  logic [7:0]        cd_out_q, cd_out_d;
  logic [NUM_CH-1:0] req_q, req_d;
  logic              wr_q, wr_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              timeout_q, timeout_d;

  logic              hit;
  logic [NUM_CH-1:0] hit_oh;
  logic [7:0]        data_sel;
  logic              ack_sel;
  logic              rd_fall, wr_fall;
  logic              act_s, rose_now;

  assign rd_s    = rd_sync[SYNC_STAGES-1];
  assign wr_s    = wr_sync[SYNC_STAGES-1];
  assign rd_fall = rd_prev & ~rd_s;
  assign wr_fall = wr_prev & ~wr_s;
  assign act_s   = is_wr_q ? wr_s : rd_s;
  assign rose_now = rose_q | act_s;
  assign ack_sel = |(bus.ack & sel_q);

  // Strobe synchronisers and one-cycle-delayed copies for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_sync <= '1;
      wr_sync <= '1;
      rd_prev <= 1'b1;
      wr_prev <= 1'b1;
    end else begin
      if (SYNC_STAGES > 1) begin
        rd_sync <= {rd_sync[SYNC_STAGES-2:0], bus.rd_iorq_n};
        wr_sync <= {wr_sync[SYNC_STAGES-2:0], bus.wr_iorq_n};
      end else begin
        rd_sync <= {SYNC_STAGES{bus.rd_iorq_n}};
        wr_sync <= {SYNC_STAGES{bus.wr_iorq_n}};
      end
      rd_prev <= rd_s;
      wr_prev <= wr_s;
    end
  end

  // Address decode: lowest matching channel index wins
  always_comb begin
    hit    = 1'b0;
    hit_oh = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (((bus.A ^ CH_BASE[i*6 +: 6]) & CH_MASK[i*6 +: 6]) == 6'd0) begin
        hit       = 1'b1;
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  // Read-data mux for the selected (one-hot) channel
  always_comb begin
    data_sel = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      data_sel = data_sel | (bus.data_in[i*8 +: 8] & {8{sel_q[i]}});
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    sel_d      = sel_q;
    rd_txn_d   = rd_txn_q;
    is_wr_d    = is_wr_q;
    rose_d     = rose_q;
    cnt_d      = cnt_q;
    cs_n_d     = cs_n_q;
    cd_oe_d    = cd_oe_q;
    cd_out_d   = cd_out_q;
    req_d      = '0;
    wr_d       = wr_q;
    data_out_d = data_out_q;
    timeout_d  = 1'b0;

    case (state_q)
      ST_ARM: begin
        if (arm_cnt_q != 2'(SYNC_STAGES)) begin
          arm_cnt_d = arm_cnt_q + 2'd1;
        end else if (rd_s && wr_s) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (rd_fall && wr_fall) begin
          // Simultaneous read and write strobes are nonsense: ignore it.
          sel_d    = '0;
          rd_txn_d = 1'b0;
          rose_d   = 1'b0;
          state_d  = ST_HOLD;
        end else if ((rd_fall && wr_s) || (wr_fall && rd_s)) begin
          is_wr_d    = wr_fall;
          wr_d       = wr_fall;
          data_out_d = bus.cd_in;
          rose_d     = 1'b0;
          if (hit) begin
            sel_d    = hit_oh;
            req_d    = hit_oh;
            cs_n_d   = 1'b0;
            rd_txn_d = ~wr_fall;
            state_d  = ST_REQ;
          end else begin
            sel_d    = '0;
            rd_txn_d = 1'b0;
            state_d  = ST_HOLD;
          end
        end
      end

      ST_REQ: begin
        rose_d  = rose_now;
        cnt_d   = 8'd0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        rose_d = rose_now;
        if (ack_sel) begin
          // ack on the expiry cycle still wins over the timeout
          if (rd_txn_q) cd_out_d = data_sel;
          cd_oe_d = rd_txn_q & ~rose_now;
          state_d = ST_HOLD;
        end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          if (rd_txn_q) cd_out_d = 8'hFF;
          cd_oe_d = rd_txn_q & ~rose_now;
          state_d = ST_HOLD;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end

      ST_HOLD: begin
        if (rd_s && wr_s) begin
          cs_n_d  = 1'b1;
          cd_oe_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_ARM;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_ARM;
      arm_cnt_q  <= 2'd0;
      sel_q      <= '0;
      rd_txn_q   <= 1'b0;
      is_wr_q    <= 1'b0;
      rose_q     <= 1'b0;
      cnt_q      <= 8'd0;
      cs_n_q     <= 1'b1;
      cd_oe_q    <= 1'b0;
      cd_out_q   <= 8'h00;
      req_q      <= '0;
      wr_q       <= 1'b0;
      data_out_q <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      sel_q      <= sel_d;
      rd_txn_q   <= rd_txn_d;
      is_wr_q    <= is_wr_d;
      rose_q     <= rose_d;
      cnt_q      <= cnt_d;
      cs_n_q     <= cs_n_d;
      cd_oe_q    <= cd_oe_d;
      cd_out_q   <= cd_out_d;
      req_q      <= req_d;
      wr_q       <= wr_d;
      data_out_q <= data_out_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.cs_n     = cs_n_q;
  assign bus.cd_oe    = cd_oe_q;
  assign bus.cd_out   = cd_out_q;
  assign bus.req      = req_q;
  assign bus.wr       = wr_q;
  assign bus.data_out = data_out_q;
  assign bus.timeout  = timeout_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Bench for cpu_io_bridge: default-parameter instance plus a second
// instance with a relaxed channel-0 mask, both fed the same CPU stimulus.
module tb_cpu_io_bridge;

  localparam logic [2:0] S_ARM  = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [5:0]  a;
  logic        rd_n, wr_n;
  logic [7:0]  cd_in;
  logic [15:0] data_in;
  logic [1:0]  ack;
  logic [2:0]  st, st_m;

  cpu_io_bridge_if #(.NUM_CH(2)) bus ();
  cpu_io_bridge_if #(.NUM_CH(2)) bus_m ();

  assign bus.A = a;           assign bus_m.A = a;
  assign bus.rd_iorq_n = rd_n; assign bus_m.rd_iorq_n = rd_n;
  assign bus.wr_iorq_n = wr_n; assign bus_m.wr_iorq_n = wr_n;
  assign bus.cd_in = cd_in;   assign bus_m.cd_in = cd_in;
  assign bus.data_in = data_in; assign bus_m.data_in = data_in;
  assign bus.ack = ack;       assign bus_m.ack = ack;

  cpu_io_bridge u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .state_dbg(st)
  );

  cpu_io_bridge #(.CH_MASK({6'h3F, 6'h3C})) u_mask (
    .clk(clk), .reset_n(reset_n), .bus(bus_m.slave), .state_dbg(st_m)
  );

  // ---------------- scoreboard ----------------
  // item = {req one-hot, wr, data}: data_out for writes, final cd_out for reads
  logic [10:0] exp_q[$];
  logic [10:0] exp_item;
  int n_vec = 0;
  int n_err = 0;

  // observations filled in by run_xact
  int         req_cyc, req_cnt, cs_fall, cs_rise, oe_first, oe_last, to_cyc, to_cnt;
  logic [1:0] req_val;
  logic       wr_at_req;
  logic [7:0] dout_at_req, cdout_end;

  // ---------------- driver ----------------
  // Drives one strobe at a negedge (cycle 0) and samples at each following
  // negedge k; sample k reflects the k-th posedge after the strobe fell.
  task automatic run_xact(input logic use_m, input logic is_wr, input logic [5:0] addr,
                          input logic [7:0] dat, input logic [1:0] ack_val,
                          input int ack_dly, input int rel_at, input int n_cyc);
    logic [1:0] o_req;
    logic       o_cs_n, o_oe, o_to, o_wr;
    logic [7:0] o_dout, o_cdout;
    req_cyc = -1; req_cnt = 0; cs_fall = -1; cs_rise = -1;
    oe_first = -1; oe_last = -1; to_cyc = -1; to_cnt = 0;
    req_val = 2'b00; wr_at_req = 1'b0; dout_at_req = 8'h00; cdout_end = 8'h00;
    @(negedge clk);
    a = addr; cd_in = dat;
    if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
    for (int k = 1; k <= n_cyc; k++) begin
      @(negedge clk);
      o_req   = use_m ? bus_m.req      : bus.req;
      o_cs_n  = use_m ? bus_m.cs_n     : bus.cs_n;
      o_oe    = use_m ? bus_m.cd_oe    : bus.cd_oe;
      o_to    = use_m ? bus_m.timeout  : bus.timeout;
      o_wr    = use_m ? bus_m.wr       : bus.wr;
      o_dout  = use_m ? bus_m.data_out : bus.data_out;
      o_cdout = use_m ? bus_m.cd_out   : bus.cd_out;
      if (o_req != 2'b00) begin
        req_cnt++;
        if (req_cyc < 0) begin
          req_cyc = k; req_val = o_req; wr_at_req = o_wr; dout_at_req = o_dout;
        end
      end
      if (!o_cs_n && cs_fall < 0) cs_fall = k;
      if (o_cs_n && cs_fall >= 0 && cs_rise < 0) cs_rise = k;
      if (o_oe) begin
        if (oe_first < 0) oe_first = k;
        oe_last = k;
      end
      if (o_to) begin
        to_cnt++;
        if (to_cyc < 0) to_cyc = k;
      end
      cdout_end = o_cdout;
      ack = 2'b00;
      if (req_cyc > 0 && ack_dly > 0 && k == req_cyc + ack_dly) ack = ack_val;
      if (k == rel_at) begin rd_n = 1'b1; wr_n = 1'b1; end
    end
    ack = 2'b00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; rd_n = 1'b1; wr_n = 1'b1; a = 6'h00; cd_in = 8'h00;
    data_in = 16'h0000; ack = 2'b00;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.cs_n, bus.cd_oe, bus.cd_out, bus.req, bus.wr, bus.data_out, bus.timeout, st}
        !== {1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, S_ARM}) begin
      n_err++;
      $display("FAIL reset_outputs: got cs_n=%b oe=%b cd_out=%h req=%b wr=%b dout=%h to=%b st=%0d, want 1 0 00 00 0 00 0 0",
               bus.cs_n, bus.cd_oe, bus.cd_out, bus.req, bus.wr, bus.data_out, bus.timeout, st);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if (st !== S_IDLE) begin
      n_err++; $display("FAIL arm_to_idle: got state %0d want %0d", st, S_IDLE);
    end
  endtask

  task automatic test_write();
    data_in = 16'h0000;
    exp_q.push_back({2'b01, 1'b1, 8'h5A});
    run_xact(1'b0, 1'b1, 6'h26, 8'h5A, 2'b01, 2, 10, 16);
    exp_item = exp_q.pop_front();
    n_vec++;
    if ({req_val, wr_at_req, dout_at_req} !== exp_item) begin
      n_err++; $display("FAIL write_item: got %h want %h", {req_val, wr_at_req, dout_at_req}, exp_item);
    end
    n_vec++;
    if (req_cnt !== 1) begin n_err++; $display("FAIL write_req_width: got %0d cycles want 1", req_cnt); end
    n_vec++;
    if (req_cyc !== 3) begin n_err++; $display("FAIL write_req_latency: got %0d want 3", req_cyc); end
    n_vec++;
    if (cs_fall !== 3) begin n_err++; $display("FAIL write_cs_fall: got %0d want 3", cs_fall); end
    n_vec++;
    if (cs_rise !== 13) begin n_err++; $display("FAIL write_cs_release: got %0d want 13", cs_rise); end
    n_vec++;
    if (oe_first !== -1) begin n_err++; $display("FAIL write_no_oe: got cd_oe at %0d want never", oe_first); end
  endtask

  task automatic test_read_ch1();
    data_in = 16'hC300;
    exp_q.push_back({2'b10, 1'b0, 8'hC3});
    run_xact(1'b0, 1'b0, 6'h14, 8'h00, 2'b10, 1, 10, 16);
    exp_item = exp_q.pop_front();
    n_vec++;
    if ({req_val, wr_at_req, cdout_end} !== exp_item) begin
      n_err++; $display("FAIL read1_item: got %h want %h", {req_val, wr_at_req, cdout_end}, exp_item);
    end
    n_vec++;
    if (req_cyc !== 3) begin n_err++; $display("FAIL read1_latency: got %0d want 3", req_cyc); end
    n_vec++;
    if (oe_first !== 5) begin n_err++; $display("FAIL read1_oe_start: got %0d want 5", oe_first); end
    n_vec++;
    if (oe_last !== 12) begin n_err++; $display("FAIL read1_oe_end: got %0d want 12", oe_last); end
    n_vec++;
    if (cs_rise !== 13) begin n_err++; $display("FAIL read1_cs_release: got %0d want 13", cs_rise); end
  endtask

  task automatic test_mask_decode();
    data_in = 16'h0096;
    exp_q.push_back({2'b01, 1'b0, 8'h96});
    run_xact(1'b1, 1'b0, 6'h27, 8'h00, 2'b01, 1, 10, 16);
    exp_item = exp_q.pop_front();
    n_vec++;
    if ({req_val, wr_at_req, cdout_end} !== exp_item) begin
      n_err++; $display("FAIL mask_hit_item: got %h want %h", {req_val, wr_at_req, cdout_end}, exp_item);
    end
    run_xact(1'b1, 1'b0, 6'h30, 8'h00, 2'b01, 1, 10, 16);
    n_vec++;
    if (req_cyc !== -1) begin n_err++; $display("FAIL mask_miss_req: got req at %0d want none", req_cyc); end
    n_vec++;
    if (cs_fall !== -1) begin n_err++; $display("FAIL mask_miss_cs: got cs_n low at %0d want never", cs_fall); end
    n_vec++;
    if (oe_first !== -1) begin n_err++; $display("FAIL mask_miss_oe: got cd_oe at %0d want never", oe_first); end
  endtask

  task automatic test_timeout();
    // ack only on the non-selected channel: must be ignored
    data_in = 16'h1111;
    exp_q.push_back({2'b01, 1'b0, 8'hFF});
    run_xact(1'b0, 1'b0, 6'h26, 8'h00, 2'b10, 1, 25, 32);
    exp_item = exp_q.pop_front();
    n_vec++;
    if ({req_val, wr_at_req, cdout_end} !== exp_item) begin
      n_err++; $display("FAIL timeout_item: got %h want %h", {req_val, wr_at_req, cdout_end}, exp_item);
    end
    n_vec++;
    if (to_cyc !== 19) begin n_err++; $display("FAIL timeout_time: got %0d want 19", to_cyc); end
    n_vec++;
    if (to_cnt !== 1) begin n_err++; $display("FAIL timeout_width: got %0d want 1", to_cnt); end
    n_vec++;
    if (oe_first !== 19) begin n_err++; $display("FAIL timeout_oe: got %0d want 19", oe_first); end
    n_vec++;
    if (cs_rise !== 28) begin n_err++; $display("FAIL timeout_release: got %0d want 28", cs_rise); end
  endtask

  task automatic test_ack_at_expiry();
    data_in = 16'h00A5;
    exp_q.push_back({2'b01, 1'b0, 8'hA5});
    run_xact(1'b0, 1'b0, 6'h26, 8'h00, 2'b01, 15, 25, 32);
    exp_item = exp_q.pop_front();
    n_vec++;
    if ({req_val, wr_at_req, cdout_end} !== exp_item) begin
      n_err++; $display("FAIL expiry_item: got %h want %h", {req_val, wr_at_req, cdout_end}, exp_item);
    end
    n_vec++;
    if (to_cnt !== 0) begin n_err++; $display("FAIL expiry_no_timeout: got %0d pulses want 0", to_cnt); end
    n_vec++;
    if (oe_first !== 19) begin n_err++; $display("FAIL expiry_oe: got %0d want 19", oe_first); end
  endtask

  task automatic test_strobe_rise_in_wait();
    data_in = 16'h007E;
    exp_q.push_back({2'b01, 1'b0, 8'h7E});
    run_xact(1'b0, 1'b0, 6'h26, 8'h00, 2'b01, 8, 6, 20);
    exp_item = exp_q.pop_front();
    n_vec++;
    if ({req_val, wr_at_req, cdout_end} !== exp_item) begin
      n_err++; $display("FAIL early_rise_item: got %h want %h", {req_val, wr_at_req, cdout_end}, exp_item);
    end
    n_vec++;
    if (oe_first !== -1) begin n_err++; $display("FAIL early_rise_oe: got cd_oe at %0d want never", oe_first); end
    n_vec++;
    if (cs_rise !== 13) begin n_err++; $display("FAIL early_rise_release: got %0d want 13", cs_rise); end
    n_vec++;
    if (to_cnt !== 0) begin n_err++; $display("FAIL early_rise_timeout: got %0d want 0", to_cnt); end
  endtask

  task automatic test_back_to_back();
    logic       w;
    logic       ch;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      w  = 1'($urandom_range(0, 1));
      ch = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      data_in = {d, d};
      exp_q.push_back({(ch ? 2'b10 : 2'b01), w, d});
      run_xact(1'b0, w, (ch ? 6'h14 : 6'h26), d, (ch ? 2'b10 : 2'b01), 1, 8, 12);
      exp_item = exp_q.pop_front();
      n_vec++;
      if ({req_val, wr_at_req, (w ? dout_at_req : cdout_end)} !== exp_item) begin
        n_err++;
        $display("FAIL b2b_item[%0d]: got %h want %h", i, {req_val, wr_at_req, (w ? dout_at_req : cdout_end)}, exp_item);
      end
      n_vec++;
      if (req_cyc !== 3) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d want 3", i, req_cyc); end
    end
  endtask

  task automatic test_reset_strobe_low();
    int bad;
    @(negedge clk);
    reset_n = 1'b0; rd_n = 1'b0; a = 6'h26;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.req != 2'b00 || !bus.cs_n) bad++;
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL rst_low_no_req: got %0d active cycles want 0", bad); end
    n_vec++;
    if (st !== S_ARM) begin n_err++; $display("FAIL rst_low_arm: got state %0d want %0d", st, S_ARM); end
    rd_n = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if (st !== S_IDLE) begin n_err++; $display("FAIL rst_low_idle: got state %0d want %0d", st, S_IDLE); end
    data_in = 16'h3C00;
    exp_q.push_back({2'b10, 1'b0, 8'h3C});
    run_xact(1'b0, 1'b0, 6'h14, 8'h00, 2'b10, 1, 10, 16);
    exp_item = exp_q.pop_front();
    n_vec++;
    if ({req_val, wr_at_req, cdout_end} !== exp_item) begin
      n_err++; $display("FAIL rst_low_item: got %h want %h", {req_val, wr_at_req, cdout_end}, exp_item);
    end
  endtask

  task automatic test_reset_in_wait();
    int bad;
    @(negedge clk);
    data_in = 16'h00EE; a = 6'h26; rd_n = 1'b0;
    repeat (6) @(negedge clk);
    n_vec++;
    if ({st, bus.cs_n} !== {S_WAIT, 1'b0}) begin
      n_err++; $display("FAIL rst_wait_pre: got state %0d cs_n %b want %0d 0", st, bus.cs_n, S_WAIT);
    end
    reset_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.cs_n, bus.cd_oe, bus.cd_out, bus.req, bus.wr, bus.data_out, bus.timeout, st}
        !== {1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, S_ARM}) begin
      n_err++;
      $display("FAIL rst_wait_outputs: got cs_n=%b oe=%b cd_out=%h req=%b wr=%b dout=%h to=%b st=%0d, want 1 0 00 00 0 00 0 0",
               bus.cs_n, bus.cd_oe, bus.cd_out, bus.req, bus.wr, bus.data_out, bus.timeout, st);
    end
    reset_n = 1'b1;
    ack = 2'b01;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.req != 2'b00 || bus.cd_oe || bus.cd_out != 8'h00 || st != S_ARM) bad++;
    end
    ack = 2'b00;
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL rst_wait_late_ack: got %0d bad cycles want 0", bad); end
    rd_n = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if (st !== S_IDLE) begin n_err++; $display("FAIL rst_wait_rearm: got state %0d want %0d", st, S_IDLE); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write();
    test_read_ch1();
    test_mask_decode();
    test_timeout();
    test_ack_at_expiry();
    test_strobe_rise_in_wait();
    test_back_to_back();
    test_reset_strobe_low();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
